// File: rtl/obi_avm_host_bridge_if.sv
// Core-side OBI and fabric-side Avalon-MM signals of one bridge port.
// slave: bridge view; master: core plus interconnect view.
interface obi_avm_host_bridge_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              req;
  logic              gnt;
  logic              we;
  logic [BE_W-1:0]   be;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  logic              avm_read;
  logic              avm_write;
  logic [ADDR_W-1:0] avm_address;
  logic [BE_W-1:0]   avm_byteenable;
  logic [DATA_W-1:0] avm_writedata;
  logic              avm_waitrequest;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_readdatavalid;
  logic              avm_writeresponsevalid;
  logic [1:0]        avm_response;

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata, err,
    output avm_read, avm_write, avm_address,
    output avm_byteenable, avm_writedata,
    input  avm_waitrequest, avm_readdata,
    input  avm_readdatavalid,
    input  avm_writeresponsevalid,
    input  avm_response
  );

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata, err,
    input  avm_read, avm_write, avm_address,
    input  avm_byteenable, avm_writedata,
    output avm_waitrequest, avm_readdata,
    output avm_readdatavalid,
    output avm_writeresponsevalid,
    output avm_response
  );
endinterface

// File: rtl/obi_avm_host_bridge.sv
// OBI host to Avalon-MM host bridge with outstanding tracking.
// Define OBI_AVM_BRIDGE_TIMEOUT_EN to add the response watchdog.
module obi_avm_host_bridge #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned START_DELAY     = 5400,
  parameter int unsigned TIMEOUT_CYCLES  = 1024,
  localparam int unsigned CNT_W =
    $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  obi_avm_host_bridge_if.slave bus,
  output logic                 ready_o,
  output logic [CNT_W-1:0]     outstanding_o,
  output logic                 protocol_err_o
);

  localparam int unsigned PTR_W =
    (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned DLY_W =
    (START_DELAY > 0) ? $clog2(START_DELAY + 1) : 1;
  localparam int unsigned TO_W =
    $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] MAX_CNT =
    CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_PTR =
    PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [DLY_W-1:0] DLY_END =
    DLY_W'(START_DELAY);

  logic [DLY_W-1:0]           dly_q, dly_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [PTR_W-1:0]           wptr_q, wptr_d;
  logic [PTR_W-1:0]           rptr_q, rptr_d;
  logic [MAX_OUTSTANDING-1:0] type_q, type_d;
  logic                       perr_q, perr_d;

  logic room;
  logic gnt;
  logic empty;
  logic head_we;
  logic rdv;
  logic wrv;
  logic acc_rd;
  logic acc_wr;
  logic accept;
  logic viol;
  logic fire;
  logic pop;

  function automatic logic [PTR_W-1:0] ptr_inc(
    input logic [PTR_W-1:0] p
  );
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Request path and response classification.
  always_comb begin
    ready_o = (dly_q == DLY_END);
    room    = ready_o && (cnt_q < MAX_CNT);
    gnt     = bus.req & room & ~bus.avm_waitrequest;

    bus.gnt            = gnt;
    bus.avm_read       = bus.req & ~bus.we & room;
    bus.avm_write      = bus.req & bus.we & room;
    bus.avm_address    = ADDR_W'(bus.addr);
    bus.avm_byteenable = bus.be;
    bus.avm_writedata  = DATA_W'(bus.wdata);

    empty   = (cnt_q == '0);
    head_we = type_q[rptr_q];
    rdv     = bus.avm_readdatavalid;
    wrv     = bus.avm_writeresponsevalid;
    acc_rd  = ~empty & ~head_we & rdv;
    acc_wr  = ~empty & head_we & wrv;
    accept  = acc_rd | acc_wr;
    viol    = ((rdv | wrv) & ~accept) | (rdv & wrv);
  end

`ifdef OBI_AVM_BRIDGE_TIMEOUT_EN
  logic [TO_W-1:0] wd_q, wd_d;

  // A real response in the firing cycle wins over the synthetic one.
  always_comb begin
    fire = ~empty & ~accept &
           (wd_q == TO_W'(TIMEOUT_CYCLES));
    wd_d = wd_q + TO_W'(1);
    if (empty || accept || fire) begin
      wd_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  logic [TO_W-1:0] wd_unused;

  assign wd_unused = '0;
  assign fire      = 1'b0;
`endif

  // Response path and bookkeeping.
  always_comb begin
    pop = accept | fire;

    bus.rvalid = pop;
    bus.rdata  = acc_rd ? bus.avm_readdata : '0;
    bus.err    = accept ? (bus.avm_response != 2'b00)
                        : fire;

    dly_d  = ready_o ? dly_q : dly_q + DLY_W'(1);
    cnt_d  = cnt_q + CNT_W'(gnt) - CNT_W'(pop);
    wptr_d = gnt ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = pop ? ptr_inc(rptr_q) : rptr_q;
    type_d = type_q;
    if (gnt) begin
      type_d[wptr_q] = bus.we;
    end
    perr_d = perr_q | viol | fire;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      dly_q  <= '0;
      cnt_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      perr_q <= 1'b0;
    end else begin
      dly_q  <= dly_d;
      cnt_q  <= cnt_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      perr_q <= perr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    type_q <= type_d;
  end

  assign outstanding_o  = cnt_q;
  assign protocol_err_o = perr_q;

endmodule

// File: tb/tb_obi_avm_host_bridge.sv
// Directed bench for obi_avm_host_bridge with a response scoreboard.
// Define OBI_AVM_BRIDGE_TIMEOUT_EN to also cover the watchdog.
module tb_obi_avm_host_bridge;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned MAXO = 4;
  localparam int unsigned SD   = 10;
  localparam int unsigned TO   = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ready;
  logic       perr;
  logic [2:0] outst;

  always #5 clk = ~clk;

  obi_avm_host_bridge_if #(
    .ADDR_W(AW),
    .DATA_W(DW)
  ) b ();

  obi_avm_host_bridge #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .MAX_OUTSTANDING(MAXO),
    .START_DELAY    (SD),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .bus           (b.slave),
    .ready_o       (ready),
    .outstanding_o (outst),
    .protocol_err_o(perr)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;
  int   peak    = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic expect_rsp(input logic [31:0] dv,
                            input logic ev);
    exp_q.push_back('{d: dv, e: ev});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    b.req                    = 1'b0;
    b.we                     = 1'b0;
    b.be                     = 4'hF;
    b.addr                   = '0;
    b.wdata                  = '0;
    b.avm_waitrequest        = 1'b0;
    b.avm_readdata           = '0;
    b.avm_readdatavalid      = 1'b0;
    b.avm_writeresponsevalid = 1'b0;
    b.avm_response           = 2'b00;
  endtask

  // Every cycle either a queued response is due or rvalid must stay low.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("rsp_valid", b.rvalid, 1);
        chk("rsp_rdata", b.rdata, mon_e.d);
        chk("rsp_err", b.err, mon_e.e);
      end else begin
        chk("idle_rvalid", b.rvalid, 0);
      end
    end
  end

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (3) tick();
    mon_en = 1'b1;
    b.req  = 1'b1;
    b.addr = 32'h100;
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_outst", outst, 0);
    chk("rst_perr", perr, 0);
    chk("rst_gnt", b.gnt, 0);

    // start gate
    rst_n = 1'b1;
    for (int i = 0; i < SD; i++) begin
      chk("gate_gnt", b.gnt, 0);
      chk("gate_rd", b.avm_read, 0);
      chk("gate_ready", ready, 0);
      tick();
    end
    #1;
    chk("gate_ready_hi", ready, 1);
    chk("gate_open", b.gnt, 1);
    tick();
    b.req               = 1'b0;
    b.avm_readdatavalid = 1'b1;
    b.avm_readdata      = 32'h11;
    expect_rsp(32'h11, 1'b0);
    #1;
    chk("gate_outst1", outst, 1);
    tick();
    b.avm_readdatavalid = 1'b0;
    #1;
    chk("gate_outst0", outst, 0);

    // pipelined reads, data three cycles after grant
    tick();
    for (int c = 0; c < 7; c++) begin
      int g;
      int r;
      b.req               = (c < 4);
      b.we                = 1'b0;
      b.addr              = 32'h200 + 32'(4 * c);
      b.avm_readdatavalid = (c >= 3);
      if (c >= 3) begin
        b.avm_readdata = 32'hA0 + 32'(c - 3);
        expect_rsp(32'hA0 + 32'(c - 3), 1'b0);
      end
      g = (c < 4) ? c : 4;
      r = (c > 3) ? c - 3 : 0;
      #1;
      if (c < 4) chk("pipe_gnt", b.gnt, 1);
      chk("pipe_outst", outst, 64'(g - r));
      if (int'(outst) > peak) peak = int'(outst);
      tick();
    end
    b.req               = 1'b0;
    b.avm_readdatavalid = 1'b0;
    #1;
    chk("pipe_peak", 64'(peak), 3);
    chk("pipe_outst_end", outst, 0);

    // waitrequest stall, then fill to the limit
    tick();
    b.req             = 1'b1;
    b.addr            = 32'h300;
    b.avm_waitrequest = 1'b1;
    #1;
    chk("wait_rd", b.avm_read, 1);
    chk("wait_gnt", b.gnt, 0);
    tick();
    #1;
    chk("wait_outst", outst, 0);
    tick();
    b.avm_waitrequest = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fill_gnt", b.gnt, 1);
      tick();
    end
    #1;
    chk("full_outst", outst, MAXO);
    b.we = 1'b1;
    #1;
    chk("full_wr", b.avm_write, 0);
    chk("full_rd", b.avm_read, 0);
    chk("full_gnt", b.gnt, 0);
    tick();
    b.avm_readdatavalid = 1'b1;
    b.avm_readdata      = 32'hB0;
    expect_rsp(32'hB0, 1'b0);
    #1;
    chk("full_rsp_gnt", b.gnt, 0);
    tick();
    b.avm_readdata = 32'hB1;
    expect_rsp(32'hB1, 1'b0);
    #1;
    chk("swap_gnt", b.gnt, 1);
    chk("swap_outst_pre", outst, 3);
    tick();
    b.req          = 1'b0;
    b.avm_readdata = 32'hB2;
    expect_rsp(32'hB2, 1'b0);
    #1;
    chk("swap_outst", outst, 3);
    tick();
    b.avm_readdata = 32'hB3;
    expect_rsp(32'hB3, 1'b0);
    tick();
    b.avm_readdatavalid      = 1'b0;
    b.avm_writeresponsevalid = 1'b1;
    b.avm_readdata           = 32'hFFFF_FFFF;
    expect_rsp(32'h0, 1'b0);
    tick();
    b.avm_writeresponsevalid = 1'b0;
    #1;
    chk("drain_outst", outst, 0);

    // write then read, write answered with an error
    b.req   = 1'b1;
    b.we    = 1'b1;
    b.addr  = 32'h400;
    b.be    = 4'h3;
    b.wdata = 32'hCAFE_F00D;
    #1;
    chk("pass_addr", b.avm_address, 32'h400);
    chk("pass_be", b.avm_byteenable, 4'h3);
    chk("pass_wdata", b.avm_writedata, 32'hCAFE_F00D);
    chk("mix_wgnt", b.gnt, 1);
    tick();
    b.we   = 1'b0;
    b.addr = 32'h404;
    #1;
    chk("mix_rgnt", b.gnt, 1);
    tick();
    b.req                    = 1'b0;
    b.avm_writeresponsevalid = 1'b1;
    b.avm_response           = 2'b10;
    b.avm_readdata           = 32'hDEAD_BEEF;
    expect_rsp(32'h0, 1'b1);
    tick();
    b.avm_writeresponsevalid = 1'b0;
    b.avm_response           = 2'b00;
    b.avm_readdatavalid      = 1'b1;
    b.avm_readdata           = 32'h55;
    expect_rsp(32'h55, 1'b0);
    tick();
    b.avm_readdatavalid = 1'b0;
    #1;
    chk("mix_outst", outst, 0);
    chk("mix_perr", perr, 0);

    // wrong response type against a read at the head
    b.req = 1'b1;
    #1;
    chk("wt_gnt", b.gnt, 1);
    tick();
    b.req                    = 1'b0;
    b.avm_writeresponsevalid = 1'b1;
    #1;
    chk("wt_rvalid", b.rvalid, 0);
    tick();
    b.avm_writeresponsevalid = 1'b0;
    #1;
    chk("wt_perr", perr, 1);
    chk("wt_outst", outst, 1);
    b.avm_readdatavalid = 1'b1;
    b.avm_readdata      = 32'h77;
    expect_rsp(32'h77, 1'b0);
    tick();
    b.avm_readdatavalid = 1'b0;
    #1;
    chk("wt_outst0", outst, 0);

    // reset clears the flag; stray response on an empty FIFO
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst2_perr", perr, 0);
    chk("rst2_ready", ready, 0);
    b.avm_readdatavalid = 1'b1;
    #1;
    chk("empty_rvalid", b.rvalid, 0);
    tick();
    b.avm_readdatavalid = 1'b0;
    #1;
    chk("empty_perr", perr, 1);
    repeat (3) tick();
    #1;
    chk("perr_sticky", perr, 1);
    chk("empty_outst", outst, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("perr_clr", perr, 0);

    // both response valids together
    repeat (SD) tick();
    #1;
    chk("rdy_again", ready, 1);
    b.req = 1'b1;
    #1;
    chk("both_gnt", b.gnt, 1);
    tick();
    b.req                    = 1'b0;
    b.avm_readdatavalid      = 1'b1;
    b.avm_writeresponsevalid = 1'b1;
    b.avm_readdata           = 32'h99;
    expect_rsp(32'h99, 1'b0);
    tick();
    b.avm_readdatavalid      = 1'b0;
    b.avm_writeresponsevalid = 1'b0;
    #1;
    chk("both_perr", perr, 1);
    chk("both_outst", outst, 0);

`ifdef OBI_AVM_BRIDGE_TIMEOUT_EN
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (SD) tick();
    b.req = 1'b1;
    #1;
    chk("to_gnt", b.gnt, 1);
    tick();
    b.req = 1'b0;
    repeat (TO) tick();
    expect_rsp(32'h0, 1'b1);
    #1;
    chk("to_outst_pre", outst, 1);
    chk("to_perr_pre", perr, 0);
    tick();
    #1;
    chk("to_outst", outst, 0);
    chk("to_perr", perr, 1);
`endif

    tick();
    chk("sb_empty", 64'(exp_q.size()), 0);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
